fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of the CPU datapath. It owns the PC and the NZVC flags register. It issues requests to instruction memory over a variable-latency req/ready handshake and presents one fetched instruction at a time to decode over a valid/ready handshake. It resolves branches (B, B.cond, CBZ), which replaces the fixed PC+4 next-PC path.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// fetched-instruction handoff to decode. master = fetch unit side.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [ILEN-1:0] imem_rdata;

  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ready, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ready, imem_rdata, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and NZVC flags, fetches one instruction at
// a time from a variable-latency memory and resolves B / B.cond / CBZ redirects.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus,
  input  logic         flag_write,
  input  logic [3:0]   flags_in,
  output logic [3:0]   flags,
  input  logic         br_valid,
  input  logic [31:0]  br_instr,
  input  logic [63:0]  br_pc,
  input  logic         br_cbz_zero
);

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned FLAG_W = 4;

  typedef enum logic [1:0] {IDLE, REQ, DROP, HOLD} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic              if_valid_q, if_valid_d;
  logic [ILEN-1:0]   if_instr_q, if_instr_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic              imem_req_q, imem_req_d;
  logic [FLAG_W-1:0] flags_q;

  logic              cond_hit;
  logic              br_taken;
  logic [XLEN-1:0]   br_off;
  logic              redirect;
  logic [XLEN-1:0]   target;

  // Branch decode; B.cond sees the registered flags, never a same-cycle write.
  always_comb begin
    cond_hit = 1'b0;
    unique case (br_instr[3:0])
      4'h0:    cond_hit = flags_q[2];
      4'h1:    cond_hit = ~flags_q[2];
      4'hA:    cond_hit = (flags_q[3] == flags_q[1]);
      4'hB:    cond_hit = (flags_q[3] != flags_q[1]);
      4'hE:    cond_hit = 1'b1;
      default: cond_hit = 1'b0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    br_off   = '0;
    if (br_instr[31:26] == 6'b000101) begin
      br_taken = 1'b1;
      br_off   = {{(XLEN-28){br_instr[25]}}, br_instr[25:0], 2'b00};
    end else if (br_instr[31:24] == 8'h54) begin
      br_taken = cond_hit;
      br_off   = {{(XLEN-21){br_instr[23]}}, br_instr[23:5], 2'b00};
    end else if (br_instr[31:24] == 8'hB4) begin
      br_taken = br_cbz_zero;
      br_off   = {{(XLEN-21){br_instr[23]}}, br_instr[23:5], 2'b00};
    end
  end

  assign redirect = br_valid & br_taken;
  assign target   = br_pc + br_off;

  // Next-state logic; every entry into REQ latches the request address from pc_d.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = target;
        end
        state_d    = REQ;
        req_addr_d = pc_d;
      end

      REQ: begin
        if (redirect) begin
          pc_d = target;
          if (bus.imem_ready) begin
            req_addr_d = target;
          end else begin
            state_d = DROP;
          end
        end else if (bus.imem_ready) begin
          if_instr_d = bus.imem_rdata;
          if_pc_d    = req_addr_q;
          if_valid_d = 1'b1;
          pc_d       = req_addr_q + XLEN'(4);
          state_d    = HOLD;
        end
      end

      DROP: begin
        if (redirect) begin
          pc_d = target;
        end
        if (bus.imem_ready) begin
          state_d    = REQ;
          req_addr_d = pc_d;
        end
      end

      HOLD: begin
        if (redirect) begin
          if_valid_d = 1'b0;
          pc_d       = target;
          state_d    = REQ;
          req_addr_d = target;
        end else if (bus.if_ready) begin
          if_valid_d = 1'b0;
          state_d    = REQ;
          req_addr_d = pc_q;
        end
      end

      default: state_d = IDLE;
    endcase

    imem_req_d = (state_d == REQ) || (state_d == DROP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      imem_req_q <= 1'b0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      imem_req_q <= imem_req_d;
      if (flag_write) begin
        flags_q <= flags_in;
      end
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = req_addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign flags         = flags_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// fetch/branch/flag traffic against a transaction-level reference model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        flag_write;
  logic [3:0]  flags_in;
  logic [3:0]  dut_flags;
  logic        br_valid;
  logic [31:0] br_instr;
  logic [63:0] br_pc;
  logic        br_cbz_zero;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(64'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .flag_write (flag_write),
    .flags_in   (flags_in),
    .flags      (dut_flags),
    .br_valid   (br_valid),
    .br_instr   (br_instr),
    .br_pc      (br_pc),
    .br_cbz_zero(br_cbz_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  logic [63:0] m_addr;
  logic [3:0]  m_flags;
  bit          rand_flags;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h91000421 + a[31:0] * 32'h00009E37;
  endfunction

  // Branch semantics from the ISA rules, using signed offsets.
  function automatic bit model_redirect(input logic [31:0] ins, input logic [63:0] bpc,
                                        input logic z, output logic [63:0] tgt);
    longint off;
    bit     t;
    bit     n_f, z_f, v_f;
    t   = 1'b0;
    off = 0;
    n_f = m_flags[3];
    z_f = m_flags[2];
    v_f = m_flags[1];
    if (ins[31:26] == 6'b000101) begin
      t   = 1'b1;
      off = longint'($signed(ins[25:0])) * 4;
    end else if (ins[31:24] == 8'h54) begin
      off = longint'($signed(ins[23:5])) * 4;
      case (ins[3:0])
        4'h0:    t = z_f;
        4'h1:    t = !z_f;
        4'hA:    t = (n_f == v_f);
        4'hB:    t = (n_f != v_f);
        4'hE:    t = 1'b1;
        default: t = 1'b0;
      endcase
    end else if (ins[31:24] == 8'hB4) begin
      off = longint'($signed(ins[23:5])) * 4;
      t   = z;
    end
    tgt = bpc + 64'(off);
    return t;
  endfunction

  task automatic step();
    if (rand_flags) begin
      flag_write = ($urandom_range(0, 3) == 0);
      flags_in   = 4'($urandom);
    end else begin
      flag_write = 1'b0;
    end
    @(posedge clk);
    #1;
    if (flag_write) m_flags = flags_in;
    chk("flags", 64'(dut_flags), 64'(m_flags));
  endtask

  task automatic load_flags(input logic [3:0] f);
    flag_write = 1'b1;
    flags_in   = f;
    @(posedge clk);
    #1;
    flag_write = 1'b0;
    m_flags    = f;
    chk("flags_load", 64'(dut_flags), 64'(m_flags));
  endtask

  task automatic rand_branch(output logic [31:0] ins, output logic [63:0] bpc, output logic z);
    logic [31:0] r;
    logic [3:0]  cond;
    r    = $urandom;
    cond = 4'($urandom);
    case ($urandom_range(0, 3))
      0:       ins = {6'b000101, r[25:0]};
      1:       ins = {8'h54, r[23:5], 1'b0, cond};
      2:       ins = {8'hB4, r[23:0]};
      default: ins = r;
    endcase
    bpc = {$urandom, $urandom} & ~64'h3;
    z   = 1'($urandom);
  endtask

  // One fetch transaction: request, optional redirect while requesting,
  // delivery to decode, optional redirect while held.
  task automatic fetch(input int lat, input int req_k,
                       input logic [31:0] rb_i, input logic [63:0] rb_pc, input logic rb_z,
                       input int hold, input int hold_k,
                       input logic [31:0] hb_i, input logic [63:0] hb_pc, input logic hb_z);
    logic [63:0] a;
    logic [63:0] tgt;
    bit          red;
    bit          drop;
    int          n;
    n = 0;
    while (!bus.imem_req && n < 8) begin
      step();
      n++;
    end
    chk("req_seen", 64'(bus.imem_req), 64'd1);
    chk("imem_addr", bus.imem_addr, m_addr);
    a    = m_addr;
    drop = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) begin
        chk("req_hold", 64'(bus.imem_req), 64'd1);
        chk("addr_hold", bus.imem_addr, a);
      end
      bus.imem_ready = (c == lat);
      bus.imem_rdata = (c == lat) ? mem_word(a) : $urandom;
      if (c == req_k) begin
        br_valid    = 1'b1;
        br_instr    = rb_i;
        br_pc       = rb_pc;
        br_cbz_zero = rb_z;
        if (model_redirect(rb_i, rb_pc, rb_z, tgt)) begin
          drop   = 1'b1;
          m_addr = tgt;
        end
      end
      step();
      br_valid       = 1'b0;
      bus.imem_ready = 1'b0;
      if (c < lat || drop) chk("no_valid_req", 64'(bus.if_valid), 64'd0);
    end
    if (drop) return;

    chk("if_valid", 64'(bus.if_valid), 64'd1);
    chk("if_instr", 64'(bus.if_instr), 64'(mem_word(a)));
    chk("if_pc", bus.if_pc, a);
    chk("req_low_hold", 64'(bus.imem_req), 64'd0);
    m_addr = a + 64'd4;
    for (int h = 0; h <= hold; h++) begin
      bus.if_ready = (h == hold);
      red = 1'b0;
      if (h == hold_k) begin
        br_valid    = 1'b1;
        br_instr    = hb_i;
        br_pc       = hb_pc;
        br_cbz_zero = hb_z;
        red = model_redirect(hb_i, hb_pc, hb_z, tgt);
      end
      step();
      br_valid     = 1'b0;
      bus.if_ready = 1'b0;
      if (red) begin
        m_addr = tgt;
        chk("flush", 64'(bus.if_valid), 64'd0);
        return;
      end
      if (h < hold) begin
        chk("stall_valid", 64'(bus.if_valid), 64'd1);
        chk("stall_instr", 64'(bus.if_instr), 64'(mem_word(a)));
        chk("stall_pc", bus.if_pc, a);
        chk("stall_req", 64'(bus.imem_req), 64'd0);
      end else begin
        chk("accept_drop", 64'(bus.if_valid), 64'd0);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   64'(bus.imem_req), 64'd0);
    chk({tag, "_addr"},  bus.imem_addr, 64'd0);
    chk({tag, "_valid"}, 64'(bus.if_valid), 64'd0);
    chk({tag, "_instr"}, 64'(bus.if_instr), 64'd0);
    chk({tag, "_pc"},    bus.if_pc, 64'd0);
    chk({tag, "_flags"}, 64'(dut_flags), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ri, hi;
    logic [63:0] rp, hp;
    logic        rz, hz;
    vectors        = 0;
    miscompares    = 0;
    rand_flags     = 1'b0;
    m_flags        = 4'h0;
    m_addr         = 64'h0;
    reset          = 1'b0;
    flag_write     = 1'b0;
    flags_in       = 4'h0;
    br_valid       = 1'b0;
    br_instr       = 32'h0;
    br_pc          = 64'h0;
    br_cbz_zero    = 1'b0;
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.if_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b1;
    step();
    chk("idle_one_cycle", 64'(bus.imem_req), 64'd1);
    chk("first_addr", bus.imem_addr, 64'h0);

    // Sequential fetches with latency and decode stall.
    fetch(1, 99, 32'h0, 64'h0, 1'b0, 0, 99, 32'h0, 64'h0, 1'b0);
    fetch(0, 99, 32'h0, 64'h0, 1'b0, 3, 99, 32'h0, 64'h0, 1'b0);
    // Unconditional B in HOLD: 0x10 + 16.
    fetch(0, 99, 32'h0, 64'h0, 1'b0, 2, 1, 32'h14000004, 64'h10, 1'b0);
    chk("b_target", m_addr, 64'h20);
    // B.LT taken with N=1,V=0 (redirect on the ready cycle), then not taken with N=V.
    load_flags(4'b1000);
    fetch(0, 0, 32'h5400004B, 64'h0, 1'b0, 0, 99, 32'h0, 64'h0, 1'b0);
    chk("blt_target", m_addr, 64'h8);
    load_flags(4'b1010);
    fetch(0, 0, 32'h5400004B, 64'h0, 1'b0, 0, 99, 32'h0, 64'h0, 1'b0);
    // CBZ backwards taken, then not taken.
    fetch(0, 99, 32'h0, 64'h0, 1'b0, 1, 0, 32'hB4FFFFE0, 64'h40, 1'b1);
    chk("cbz_target", m_addr, 64'h3C);
    fetch(0, 99, 32'h0, 64'h0, 1'b0, 1, 0, 32'hB4FFFFE0, 64'h40, 1'b0);
    // Wrap-around target, then back to 8 and redirect while memory is slow.
    fetch(0, 99, 32'h0, 64'h0, 1'b0, 0, 0, 32'h14000008, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    chk("wrap_target", m_addr, 64'h10);
    fetch(0, 99, 32'h0, 64'h0, 1'b0, 0, 0, 32'h14000000, 64'h8, 1'b0);
    fetch(3, 1, 32'h14000010, 64'h100, 1'b0, 0, 99, 32'h0, 64'h0, 1'b0);
    chk("drop_target", m_addr, 64'h140);
    fetch(0, 99, 32'h0, 64'h0, 1'b0, 0, 99, 32'h0, 64'h0, 1'b0);

    // Random traffic.
    rand_flags = 1'b1;
    repeat (150) begin
      rand_branch(ri, rp, rz);
      rand_branch(hi, hp, hz);
      fetch($urandom_range(0, 3), $urandom_range(0, 6), ri, rp, rz,
            $urandom_range(0, 3), $urandom_range(0, 6), hi, hp, hz);
    end
    rand_flags = 1'b0;

    // Asynchronous reset in the middle of an outstanding request.
    fetch(2, 99, 32'h0, 64'h0, 1'b0, 0, 99, 32'h0, 64'h0, 1'b0);
    step();
    chk("pre_reset_req", 64'(bus.imem_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    chk("reset_no_valid", 64'(bus.if_valid), 64'd0);
    bus.imem_ready = 1'b0;
    reset          = 1'b1;
    m_addr         = 64'h0;
    m_flags        = 4'h0;
    step();
    chk("rerelease_req", 64'(bus.imem_req), 64'd1);
    chk("rerelease_addr", bus.imem_addr, 64'h0);
    fetch(0, 99, 32'h0, 64'h0, 1'b0, 0, 99, 32'h0, 64'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
